// File: rtl/gpu_pkg.sv
// gpu_pkg: display_type codes, layer classes, palette and fixed colours shared by the pixel fetch path.
package gpu_pkg;

  typedef enum logic [2:0] {BG, SPRITE, DIM, PANEL, UNKNOWN} pix_class_e;

  localparam logic [7:0] DT_BG    = 8'h00;
  localparam logic [7:0] DT_DIM   = 8'h32;
  localparam logic [7:0] DT_PANEL = 8'h34;

  localparam logic [23:0] PANEL_RGB = 24'h403020;
  localparam logic [23:0] DEBUG_RGB = 24'hFF00FF;

  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h204080,
    24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'h808080, 24'hC0C0C0, 24'h800000,
    24'h008000, 24'h000080, 24'h808000, 24'h008080
  };

  function automatic pix_class_e classify(input logic [7:0] dt);
    case (dt)
      DT_BG:    return BG;
      8'h01, 8'h04, 8'h05, 8'h0F, 8'h10,
      8'h20, 8'h30, 8'h31, 8'h33, 8'h35: return SPRITE;
      DT_DIM:   return DIM;
      DT_PANEL: return PANEL;
      default:  return UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/palette_lut.sv
// palette_lut: combinational 4-bit palette index to 24-bit RGB lookup.
//   idx_i : palette index
//   rgb_o : {R,G,B} colour
module palette_lut
  import gpu_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [23:0] rgb_o
);
  assign rgb_o = PALETTE[idx_i];
endmodule

// File: rtl/pixel_fetch_unit.sv
// pixel_fetch_unit: registers GPU pixel requests, drives background/sprite ROMs and merges the
// returned palette indices into 24-bit RGB through a fixed 3-cycle pipeline.
//   Clk, Reset_n                 : clock, async active-low reset
//   pix_valid, blank, DrawX/Y    : pixel request and coordinate
//   display_type, read_address   : GPU layer code and sprite-local address
//   bg_addr/bg_data              : background ROM port (1-cycle read)
//   sprite_rd/sel/addr/data      : sprite ROM port (1-cycle read)
//   Red/Green/Blue, rgb_valid    : output colour and qualifier
//   unknown_cnt                  : saturating count of unknown layer codes
module pixel_fetch_unit
  import gpu_pkg::*;
#(
  parameter int SPRITE_AW = 19,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 pix_valid,
  input  logic                 blank,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [7:0]           display_type,
  input  logic [SPRITE_AW-1:0] read_address,
  output logic [18:0]          bg_addr,
  input  logic [3:0]           bg_data,
  output logic                 sprite_rd,
  output logic [7:0]           sprite_sel,
  output logic [SPRITE_AW-1:0] sprite_addr,
  input  logic [3:0]           sprite_data,
  output logic [7:0]           Red,
  output logic [7:0]           Green,
  output logic [7:0]           Blue,
  output logic                 rgb_valid,
  output logic [CNT_W-1:0]     unknown_cnt
);

  // S1: request register, also the ROM address/select outputs
  logic                 v1_q, blank1_q;
  pix_class_e           cls1_q, cls_in;
  logic [18:0]          bg_addr_q;
  logic                 sprite_rd_q;
  logic [7:0]           sprite_sel_q;
  logic [SPRITE_AW-1:0] sprite_addr_q;
  // M: tags travelling alongside the ROM read
  logic                 v2_q, blank2_q;
  pix_class_e           cls2_q;
  // S2: returned palette indices
  logic                 v3_q, blank3_q;
  pix_class_e           cls3_q;
  logic [3:0]           bg_idx_q, sp_idx_q;
  // S3: colour and counter
  logic [23:0]          rgb_q, rgb_d, bg_rgb, sp_rgb, dim_rgb;
  logic                 rgb_valid_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign cls_in = classify(display_type);

  palette_lut u_bg_lut (.idx_i(bg_idx_q), .rgb_o(bg_rgb));
  palette_lut u_sp_lut (.idx_i(sp_idx_q), .rgb_o(sp_rgb));

  assign dim_rgb = {1'b0, bg_rgb[23:17], 1'b0, bg_rgb[15:9], 1'b0, bg_rgb[7:1]};

  always_comb begin
    rgb_d = !v3_q                ? rgb_q :
            blank3_q             ? 24'h000000 :
            cls3_q == BG         ? bg_rgb :
            cls3_q == SPRITE     ? (sp_idx_q != 4'd0 ? sp_rgb : bg_rgb) :
            cls3_q == DIM        ? dim_rgb :
            cls3_q == PANEL      ? PANEL_RGB : DEBUG_RGB;
    cnt_d = (v3_q && !blank3_q && cls3_q == UNKNOWN && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_q          <= 1'b0;
      blank1_q      <= 1'b0;
      cls1_q        <= BG;
      bg_addr_q     <= '0;
      sprite_rd_q   <= 1'b0;
      sprite_sel_q  <= '0;
      sprite_addr_q <= '0;
      v2_q          <= 1'b0;
      blank2_q      <= 1'b0;
      cls2_q        <= BG;
      v3_q          <= 1'b0;
      blank3_q      <= 1'b0;
      cls3_q        <= BG;
      bg_idx_q      <= '0;
      sp_idx_q      <= '0;
      rgb_q         <= '0;
      rgb_valid_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      v1_q        <= pix_valid;
      sprite_rd_q <= pix_valid && cls_in == SPRITE;
      if (pix_valid) begin
        blank1_q      <= blank;
        cls1_q        <= cls_in;
        // 479*640+639 fits in 19 bits, so no wrap handling is needed
        bg_addr_q     <= 19'(DrawY) * 19'd640 + 19'(DrawX);
        sprite_sel_q  <= display_type;
        sprite_addr_q <= read_address;
      end
      v2_q        <= v1_q;
      blank2_q    <= blank1_q;
      cls2_q      <= cls1_q;
      v3_q        <= v2_q;
      blank3_q    <= blank2_q;
      cls3_q      <= cls2_q;
      bg_idx_q    <= bg_data;
      sp_idx_q    <= sprite_data;
      rgb_q       <= rgb_d;
      rgb_valid_q <= v3_q;
      cnt_q       <= cnt_d;
    end
  end

  assign bg_addr     = bg_addr_q;
  assign sprite_rd   = sprite_rd_q;
  assign sprite_sel  = sprite_sel_q;
  assign sprite_addr = sprite_addr_q;
  assign {Red, Green, Blue} = rgb_q;
  assign rgb_valid   = rgb_valid_q;
  assign unknown_cnt = cnt_q;

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// tb_pixel_fetch_unit: directed self-checking bench for pixel_fetch_unit with ROM models.
module tb_pixel_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid = 1'b0, blank = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [7:0]  display_type = '0;
  logic [18:0] read_address = '0;
  logic [18:0] bg_addr, sprite_addr;
  logic [3:0]  bg_data = '0, sprite_data = '0;
  logic        sprite_rd, rgb_valid;
  logic [7:0]  sprite_sel, Red, Green, Blue;
  logic [15:0] unknown_cnt;
  logic [18:0] bg_addr2, sprite_addr2;
  logic        sprite_rd2, rgb_valid2;
  logic [7:0]  sprite_sel2, Red2, Green2, Blue2;
  logic [1:0]  unknown_cnt2;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  pixel_fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .display_type(display_type), .read_address(read_address),
    .bg_addr(bg_addr), .bg_data(bg_data), .sprite_rd(sprite_rd), .sprite_sel(sprite_sel),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data), .Red(Red), .Green(Green),
    .Blue(Blue), .rgb_valid(rgb_valid), .unknown_cnt(unknown_cnt)
  );

  // narrow-counter instance exercises saturation in a handful of pixels
  pixel_fetch_unit #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .display_type(display_type), .read_address(read_address),
    .bg_addr(bg_addr2), .bg_data(bg_data), .sprite_rd(sprite_rd2), .sprite_sel(sprite_sel2),
    .sprite_addr(sprite_addr2), .sprite_data(sprite_data), .Red(Red2), .Green(Green2),
    .Blue(Blue2), .rgb_valid(rgb_valid2), .unknown_cnt(unknown_cnt2)
  );

  // ROM models: index is the low address nibble, with two hand-picked exceptions
  always @(posedge Clk) begin
    bg_data     <= (bg_addr == 19'd307199) ? 4'd3 : bg_addr[3:0];
    sprite_data <= (sprite_addr == 19'd1012) ? 4'd1 : sprite_addr[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic b, input logic [9:0] x, input logic [9:0] y,
                      input logic [7:0] dt, input logic [18:0] ra);
    pix_valid = v; blank = b; DrawX = x; DrawY = y; display_type = dt; read_address = ra;
    @(negedge Clk);
  endtask

  task automatic idle();
    send(1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 19'd0);
  endtask

  initial begin
    @(negedge Clk); @(negedge Clk);
    chk("rst_valid", 32'(rgb_valid), 32'd0);
    chk("rst_rgb", 32'({Red, Green, Blue}), 32'h0);
    chk("rst_bg_addr", 32'(bg_addr), 32'd0);
    chk("rst_sprite", 32'({sprite_rd, sprite_sel, sprite_addr}), 32'd0);
    chk("rst_cnt", 32'(unknown_cnt), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // background pixel at the last visible coordinate
    send(1, 0, 10'd639, 10'd479, 8'h00, 19'd0);
    chk("bg_addr_max", 32'(bg_addr), 32'd307199);
    chk("bg_sprite_rd", 32'(sprite_rd), 32'd0);
    idle(); chk("bg_lat1", 32'(rgb_valid), 32'd0);
    idle(); chk("bg_lat2", 32'(rgb_valid), 32'd0);
    idle(); chk("bg_valid", 32'(rgb_valid), 32'd1);
    chk("bg_rgb", 32'({Red, Green, Blue}), 32'h204080);
    idle(); chk("bg_bubble", 32'(rgb_valid), 32'd0);
    chk("bg_hold", 32'({Red, Green, Blue}), 32'h204080);

    // opaque sprite then transparent sprite, back to back
    send(1, 0, 10'd3, 10'd0, 8'h04, 19'd1012);
    chk("sp_rd", 32'(sprite_rd), 32'd1);
    chk("sp_sel", 32'(sprite_sel), 32'h04);
    chk("sp_addr", 32'(sprite_addr), 32'd1012);
    send(1, 0, 10'd3, 10'd0, 8'h04, 19'd16);
    idle(); idle();
    chk("sp_opaque", 32'({rgb_valid, Red, Green, Blue}), 32'h1FFFFFF);
    idle(); chk("sp_transp", 32'({rgb_valid, Red, Green, Blue}), 32'h1204080);

    // dim and panel layers
    send(1, 0, 10'd3, 10'd0, 8'h32, 19'd0);
    chk("dim_sprite_rd", 32'(sprite_rd), 32'd0);
    send(1, 0, 10'd5, 10'd0, 8'h34, 19'd7);
    idle(); idle();
    chk("dim_rgb", 32'({rgb_valid, Red, Green, Blue}), 32'h1102040);
    idle(); chk("panel_rgb", 32'({rgb_valid, Red, Green, Blue}), 32'h1403020);
    send(1, 0, 10'd1, 10'd0, 8'h31, 19'd5);
    chk("sp31_rd", 32'(sprite_rd), 32'd1);
    idle(); idle(); idle();
    chk("sp31_rgb", 32'({rgb_valid, Red, Green, Blue}), 32'h10000FF);

    // unknown codes: three visible, one blank
    send(1, 0, 10'd1, 10'd0, 8'h77, 19'd0);
    chk("unk_sprite_rd", 32'(sprite_rd), 32'd0);
    send(1, 0, 10'd1, 10'd0, 8'h77, 19'd0);
    send(1, 0, 10'd1, 10'd0, 8'h77, 19'd0);
    send(1, 1, 10'd1, 10'd0, 8'h77, 19'd0);
    chk("unk_rgb0", 32'({rgb_valid, Red, Green, Blue}), 32'h1FF00FF);
    idle(); chk("unk_rgb1", 32'({rgb_valid, Red, Green, Blue}), 32'h1FF00FF);
    idle(); chk("unk_rgb2", 32'({rgb_valid, Red, Green, Blue}), 32'h1FF00FF);
    idle(); chk("unk_blank", 32'({rgb_valid, Red, Green, Blue}), 32'h1000000);
    chk("unk_cnt3", 32'(unknown_cnt), 32'd3);
    chk("unk_cnt3_narrow", 32'(unknown_cnt2), 32'd3);
    for (int i = 0; i < 3; i++) send(1, 0, 10'd2, 10'd0, 8'h02, 19'd0);
    idle(); idle(); idle();
    chk("unk_cnt6", 32'(unknown_cnt), 32'd6);
    chk("unk_sat", 32'(unknown_cnt2), 32'd3);

    // reset with two pixels in flight
    send(1, 0, 10'd3, 10'd0, 8'h00, 19'd0);
    send(1, 0, 10'd3, 10'd0, 8'h04, 19'd1012);
    pix_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({rgb_valid, Red, Green, Blue}), 32'h0);
    chk("mid_rst_addr", 32'({sprite_rd, bg_addr}), 32'd0);
    chk("mid_rst_sp", 32'({sprite_sel, sprite_addr}), 32'd0);
    chk("mid_rst_cnt", 32'(unknown_cnt), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_rst_quiet", 32'(rgb_valid), 32'd0);
    end

    // gapped stream 1,0,1,1
    send(1, 0, 10'd3, 10'd0, 8'h00, 19'd0);
    send(0, 0, 10'd9, 10'd0, 8'h00, 19'd0);
    send(1, 0, 10'd1, 10'd0, 8'h04, 19'd2);
    send(1, 0, 10'd5, 10'd0, 8'h00, 19'd0);
    chk("gap_0", 32'({rgb_valid, Red, Green, Blue}), 32'h1204080);
    idle(); chk("gap_1", 32'({rgb_valid, Red, Green, Blue}), 32'h0204080);
    idle(); chk("gap_2", 32'({rgb_valid, Red, Green, Blue}), 32'h1FF0000);
    idle(); chk("gap_3", 32'({rgb_valid, Red, Green, Blue}), 32'h10000FF);
    idle(); chk("gap_end", 32'(rgb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_fetch_unit.md
# pixel_fetch_unit

Consumer side of the GPU's per-pixel `display_type` / `read_address` stream. It registers each pixel request and drives the background and sprite memories. It merges the returned 4-bit palette indices with transparency, overlay and fallback rules, and emits 24-bit RGB to the VGA output stage through a fixed 3-cycle pipeline. It sits between `GPU` and `VGA_controller`, and owns all on-chip memory reads for display.

## Interface
Parameters:
- `SPRITE_AW`, 19: sprite/background address width; matches the GPU `read_address` width.
- `CNT_W`, 16: width of the unknown-type counter.

Ports:
- `Clk`, in, 1: 50 MHz system clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `pix_valid`, in, 1: request qualifier, one per pixel.
- `blank`, in, 1: high outside the visible area.
- `DrawX`, `DrawY`, in, 10 each: pixel coordinate.
- `display_type`, in, 8: GPU layer code.
- `read_address`, in, 19: sprite-local address.
- `bg_addr`, out, 19: background ROM address.
- `bg_data`, in, 4: background palette index, 1-cycle synchronous read.
- `sprite_rd`, out, 1: sprite read strobe.
- `sprite_sel`, out, 8: sprite ROM select.
- `sprite_addr`, out, 19: sprite ROM address.
- `sprite_data`, in, 4: sprite palette index, 1-cycle synchronous read.
- `Red`, `Green`, `Blue`, out, 8 each: pixel colour.
- `rgb_valid`, out, 1: colour qualifier.
- `unknown_cnt`, out, `CNT_W`: saturating count of unknown `display_type` codes.

## Operation
- **Stage S1 (edge after `pix_valid`=1):**
  - Register the request.
  - Set `bg_addr = DrawY*640 + DrawX`, computed at 19 bits with no wrap, because the maximum 479*640+639 fits.
  - `sprite_rd` = 1 when the class is SPRITE.
  - Copy `display_type` to `sprite_sel` and `read_address` to `sprite_addr`.
  - When `pix_valid`=0, all of the above hold their values and `sprite_rd`=0.
- **Type classes:**
  - BG: `0x00`.
  - SPRITE: `0x01 0x04 0x05 0x0F 0x10 0x20 0x30 0x31 0x33 0x35`.
  - DIM: `0x32`.
  - PANEL: `0x34`.
  - Any other code is UNKNOWN.
- **Stage S2:** capture `bg_data` and `sprite_data` with the class, the blank flag and the valid bit.
- **Stage S3, colour select (registered):**
  - blank: `Red`, `Green` and `Blue` are all 0.
  - BG: `PALETTE[bg_idx]`.
  - SPRITE with `sprite_idx != 0`: `PALETTE[sprite_idx]`.
  - SPRITE with `sprite_idx == 0` (transparent): `PALETTE[bg_idx]`.
  - DIM: each channel of `PALETTE[bg_idx]` shifted right by 1 (truncating).
  - PANEL: constant `PANEL_RGB` = 0x403020.
  - UNKNOWN: `DEBUG_RGB` = 0xFF00FF.
- **Counter:**
  - `unknown_cnt` increments by 1 in S3 for each valid, non-blank UNKNOWN pixel.
  - It saturates at all-ones and is never cleared except by reset.
- **Invalid slots:** while `rgb_valid`=0, `Red`, `Green` and `Blue` hold their last values.

## Timing
- **Latency:** a pixel presented at edge t has `rgb_valid`=1 and its colour after edge t+3.
- **Throughput:** one pixel per `Clk` when `pix_valid` is held high. Back-to-back and gapped requests are both legal, and bubbles propagate unchanged.
- **Memory contract:**
  - `bg_addr` and `sprite_addr` are stable for the whole cycle after S1.
  - The memories return data on the following edge.
  - No backpressure.
- **Reset (`Reset_n`=0):**
  - All valid bits clear.
  - `bg_addr`, `sprite_addr`, `sprite_sel`, `sprite_rd`, `Red`, `Green`, `Blue`, `rgb_valid` and `unknown_cnt` all go to 0.
  - A reset mid-stream discards all in-flight pixels; no partial output appears after release.
  - The first output appears 3 edges after the first post-reset `pix_valid`.
- **Simultaneous events:** an UNKNOWN pixel that is also blank outputs 0 and does not count.

## Structure
- Package `gpu_pkg` holds:
  - the `display_type` code constants and the class enum `{BG, SPRITE, DIM, PANEL, UNKNOWN}`;
  - `PALETTE[16]` as 24-bit constants, with `PALETTE[0]`=0x000000, `[1]`=0xFFFFFF and `[3]`=0x204080;
  - `PANEL_RGB` and `DEBUG_RGB`.
- One sub-module, `palette_lut`: a combinational 4-bit-to-24-bit lookup, instantiated twice in S3 (background and sprite index).
- A `classify` function in `gpu_pkg` maps `display_type` to its class.

## Test plan
- **Background pixel:** `display_type`=0x00, DrawX=639, DrawY=479. Expect `bg_addr`=307199, `sprite_rd`=0. With `bg_data`=3, expect RGB=0x204080 and `rgb_valid` after 3 edges.
- **Sprite opaque then transparent:** type 0x04, `read_address`=1012, `sprite_data`=1 gives 0xFFFFFF. Next pixel with `sprite_data`=0 and `bg_data`=3 gives 0x204080.
- **DIM and PANEL:** type 0x32 with `bg_data`=3 gives 0x102040. Type 0x34 gives 0x403020 regardless of the memory data.
- **Unknown codes:** stream of 3 pixels with type 0x77, then 1 blank 0x77. Expect RGB 0xFF00FF three times, then 0, with `unknown_cnt`=3. Force `unknown_cnt` to 0xFFFE and send 3 more: it saturates at 0xFFFF.
- **Reset mid-stream:** 2 pixels in flight, assert `Reset_n`=0 for 1 cycle. No `rgb_valid` appears for the discarded pixels, and all outputs read 0 during reset.
- **Gapped stream:** `pix_valid` pattern 1,0,1,1. `rgb_valid` pattern 1,0,1,1 delayed by 3 edges, with colours in order.
